// File: rtl/aes_pkg.sv
// Shared definitions for the AES block sequencer.
//   AES_BLOCK_W  : width of one AES block (plaintext, ciphertext, core I/O).
//   seq_state_e  : sequencer state encoding.
//   NIST_*       : SP800-38A ECB-AES128 vectors (key 2b7e1516...4f3c) for benches.
//   in_encrypt() : true in the states where the core is working on a block.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    INIT_GAP  = 4'd2,
    INIT_WAIT = 4'd3,
    RUN_IDLE  = 4'd4,
    NEXT      = 4'd5,
    NEXT_GAP  = 4'd6,
    NEXT_WAIT = 4'd7,
    OUT       = 4'd8,
    ERR       = 4'd9
  } seq_state_e;

  localparam logic [AES_BLOCK_W-1:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [AES_BLOCK_W-1:0] NIST_PT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [AES_BLOCK_W-1:0] NIST_PT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [AES_BLOCK_W-1:0] NIST_PT2 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [AES_BLOCK_W-1:0] NIST_PT3 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [AES_BLOCK_W-1:0] NIST_CT0 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [AES_BLOCK_W-1:0] NIST_CT1 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [AES_BLOCK_W-1:0] NIST_CT2 = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [AES_BLOCK_W-1:0] NIST_CT3 = 128'h7b0c785e27e8ad3f8223207104725dd4;

  function automatic logic in_encrypt(input seq_state_e s);
    return (s == NEXT) || (s == NEXT_GAP) || (s == NEXT_WAIT);
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous FIFO holding plaintext blocks ahead of the AES core.
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO).
//   push        : write push_data; taken when not full, or when full and
//                 popping in the same cycle (occupancy unchanged).
//   pop         : discard the head entry; ignored when empty.
//   head_data   : current head entry (valid when !empty).
//   full, empty : occupancy flags, decoded from the registered count.
//   count       : registered occupancy, 0..DEPTH.
module aes_block_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// Drives aes_core through key init and one next/result handshake per
// plaintext block, returns ciphertext on a valid/ready stream and raises a
// scope trigger while the core is encrypting.
//   clk, reset        : clock, asynchronous active-high reset.
//   start             : request key init (honoured only in IDLE).
//   pt_valid/ready/data : plaintext stream into the block FIFO.
//   core_init/next/block, core_ready/result/result_valid : aes_core handshake.
//   ct_valid/ready/data : ciphertext stream out.
//   trigger           : high from NEXT through the result capture cycle.
//   busy              : high outside IDLE and RUN_IDLE.
//   timeout_err       : sticky core-timeout flag.
//   blk_count         : ciphertexts delivered, wrapping.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// INIT      | core_init pulse
// INIT_GAP  | core still shows stale ready; ignore it
// INIT_WAIT | key expansion running, wait for core_ready
// RUN_IDLE  | key ready; fetch next block when the FIFO has one
// NEXT      | head block popped into core_block, core_next pulse
// NEXT_GAP  | core still shows stale ready/result_valid; ignore them
// NEXT_WAIT | encryption running, wait for ready && result_valid
// OUT       | ciphertext presented until ct_ready
// ERR       | core timed out; parked until reset
module aes_block_sequencer
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [AES_BLOCK_W-1:0] pt_data,
  output logic                   core_init,
  output logic                   core_next,
  output logic [AES_BLOCK_W-1:0] core_block,
  input  logic                   core_ready,
  input  logic [AES_BLOCK_W-1:0] core_result,
  input  logic                   core_result_valid,
  output logic                   ct_valid,
  input  logic                   ct_ready,
  output logic [AES_BLOCK_W-1:0] ct_data,
  output logic                   trigger,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [31:0]            blk_count
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  // The last waiting cycle is index TIMEOUT_CYCLES-1, so ERR is reached
  // exactly TIMEOUT_CYCLES cycles after entering a *_WAIT state.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [AES_BLOCK_W-1:0] core_block_q, core_block_d;
  logic [AES_BLOCK_W-1:0] ct_data_q, ct_data_d;
  logic [31:0]            blk_count_q, blk_count_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   trigger_q, trigger_d;
  logic                   pt_en_q, pt_en_d;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [AES_BLOCK_W-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCNT_W-1:0]      unused_fifo_count;

  // pt_en_q keeps pt_ready low during reset and in ERR while still
  // following the registered FIFO count everywhere else.
  assign pt_ready  = pt_en_q && !fifo_full;
  assign fifo_push = pt_valid && pt_ready;

  aes_block_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AES_BLOCK_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pt_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    core_block_d = core_block_q;
    ct_data_d    = ct_data_q;
    blk_count_d  = blk_count_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        state_d = INIT_GAP;
      end
      INIT_GAP: begin
        state_d    = INIT_WAIT;
        wait_cnt_d = '0;
      end
      INIT_WAIT: begin
        if (core_ready) begin
          state_d = RUN_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      RUN_IDLE: begin
        if (!fifo_empty) begin
          state_d      = NEXT;
          fifo_pop     = 1'b1;
          core_block_d = fifo_head;
        end
      end
      NEXT: begin
        state_d = NEXT_GAP;
      end
      NEXT_GAP: begin
        state_d    = NEXT_WAIT;
        wait_cnt_d = '0;
      end
      NEXT_WAIT: begin
        if (core_ready && core_result_valid) begin
          state_d   = OUT;
          ct_data_d = core_result;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        if (ct_ready) begin
          state_d     = RUN_IDLE;
          blk_count_d = blk_count_q + 32'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    trigger_d     = in_encrypt(state_d);
    pt_en_d       = (state_d != ERR);
    timeout_err_d = timeout_err_q || (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      core_block_q  <= '0;
      ct_data_q     <= '0;
      blk_count_q   <= '0;
      timeout_err_q <= 1'b0;
      trigger_q     <= 1'b0;
      pt_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      core_block_q  <= core_block_d;
      ct_data_q     <= ct_data_d;
      blk_count_q   <= blk_count_d;
      timeout_err_q <= timeout_err_d;
      trigger_q     <= trigger_d;
      pt_en_q       <= pt_en_d;
    end
  end

  assign core_init   = (state_q == INIT);
  assign core_next   = (state_q == NEXT);
  assign ct_valid    = (state_q == OUT);
  assign busy        = (state_q != IDLE) && (state_q != RUN_IDLE);
  assign core_block  = core_block_q;
  assign ct_data     = ct_data_q;
  assign blk_count   = blk_count_q;
  assign timeout_err = timeout_err_q;
  assign trigger     = trigger_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with a behavioural aes_core stub
// that answers the NIST ECB vectors (and ~block for any other input).
module tb_aes_block_sequencer;
  import aes_pkg::*;

  localparam int TO  = 256;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset, start, pt_valid, pt_ready;
  logic [127:0] pt_data;
  logic         core_init, core_next, core_ready, core_result_valid;
  logic [127:0] core_block, core_result;
  logic         ct_valid, ct_ready, trigger, busy, timeout_err;
  logic [127:0] ct_data;
  logic [31:0]  blk_count;

  always #5 clk = ~clk;

  aes_block_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_result(core_result),
    .core_result_valid(core_result_valid),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .trigger(trigger), .busy(busy), .timeout_err(timeout_err),
    .blk_count(blk_count)
  );

  function automatic logic [127:0] ecb(input logic [127:0] b);
    case (b)
      NIST_PT0: return NIST_CT0;
      NIST_PT1: return NIST_CT1;
      NIST_PT2: return NIST_CT2;
      NIST_PT3: return NIST_CT3;
      default:  return ~b;
    endcase
  endfunction

  // aes_core stub: ready drops the cycle after init/next, returns LAT+1 cycles later.
  logic         stub_hang = 1'b0;
  logic         stub_busy, stub_is_next;
  logic [3:0]   stub_cnt;
  logic [127:0] stub_blk;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready <= 1'b1; core_result_valid <= 1'b0; core_result <= '0;
      stub_busy <= 1'b0; stub_is_next <= 1'b0; stub_cnt <= '0; stub_blk <= '0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0; core_result_valid <= 1'b0;
      stub_busy <= 1'b1; stub_is_next <= core_next; stub_cnt <= 4'(LAT);
      stub_blk <= core_block;
    end else if (stub_busy) begin
      if (stub_cnt != 0) stub_cnt <= stub_cnt - 4'd1;
      else if (!(stub_hang && stub_is_next)) begin
        core_ready <= 1'b1;
        core_result_valid <= stub_is_next;
        if (stub_is_next) core_result <= ecb(stub_blk);
        stub_busy <= 1'b0;
      end
    end
  end

  int   init_pulses = 0, next_pulses = 0, trig_rises = 0, trig_cycles = 0, overlap = 0;
  logic trig_prev = 1'b0;
  always @(posedge clk) begin
    trig_prev <= trigger;
    if (core_init) init_pulses <= init_pulses + 1;
    if (core_next) next_pulses <= next_pulses + 1;
    if (trigger && !trig_prev) trig_rises <= trig_rises + 1;
    if (trigger) trig_cycles <= trig_cycles + 1;
    if (core_init && core_next) overlap <= overlap + 1;
  end

  int checks = 0, errors = 0;
  logic [127:0] exp_v [8];

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return !busy;
      1:       return core_next;
      2:       return ct_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Ends on the negedge where the condition is first seen.
  task automatic wait_for(input string tag, input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (probe(sel)) break;
      @(negedge clk);
    end
    check_int(tag, int'(probe(sel)), 1);
  endtask

  // Accepts n ciphertexts against exp_v while completing any pending push.
  task automatic collect(input string tag, input int n);
    int   got;
    logic pend;
    got = 0;
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ct_valid && ct_ready) begin
        check_vec($sformatf("%s_ct%0d", tag, got), ct_data, exp_v[got]);
        got++;
      end
      if (pt_valid && pt_ready) pend = 1'b1;
      @(negedge clk);
      if (pend) begin pt_valid = 1'b0; pend = 1'b0; end
      if (got >= n) break;
    end
    check_int({tag, "_count"}, got, n);
  endtask

  task automatic push_one(input logic [127:0] d);
    pt_data = d; pt_valid = 1'b1;
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  localparam logic [127:0] X1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] X2 = 128'hdeadbeef0badf00dcafef00d12345678;
  localparam logic [127:0] X3 = 128'h0f0e0d0c0b0a09080706050403020100;

  logic [127:0] pts [4];
  logic [127:0] cts [4];
  logic [127:0] bp  [5];
  int   snap_next, snap_rise, snap_cyc;
  logic stable;

  initial begin
    pts[0] = NIST_PT0; pts[1] = NIST_PT1; pts[2] = NIST_PT2; pts[3] = NIST_PT3;
    cts[0] = NIST_CT0; cts[1] = NIST_CT1; cts[2] = NIST_CT2; cts[3] = NIST_CT3;
    reset = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_int("rst_ctl", int'({core_init, core_next, ct_valid, trigger, busy, timeout_err, pt_ready}), 0);
    check_vec("rst_core_block", core_block, '0);
    check_vec("rst_ct_data", ct_data, '0);
    check_int("rst_blk_count", int'(blk_count), 0);
    reset = 1'b0;
    @(negedge clk);
    check_int("pt_ready_after_rst", int'(pt_ready), 1);

    // Key init
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_int("init_pulse", int'({core_init, busy}), 3);
    @(negedge clk);
    check_int("init_one_cycle", int'(core_init), 0);
    wait_for("init_done", 0, 30);
    check_int("init_once", init_pulses, 1);

    // start in RUN_IDLE is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_int("start_ignored_busy", int'({core_init, busy}), 0);
    repeat (3) @(negedge clk);
    check_int("start_ignored_init", init_pulses, 1);

    // Basic ECB and latency
    push_one(NIST_PT0);
    check_int("lat_cycle1", int'(core_next), 0);
    @(negedge clk);
    check_int("lat_cycle2_next_trig", int'({core_next, trigger}), 3);
    check_vec("core_block_pt0", core_block, NIST_PT0);
    wait_for("basic_ct_valid", 2, 30);
    check_vec("basic_ct", ct_data, NIST_CT0);
    check_int("basic_trig_low", int'(trigger), 0);
    @(negedge clk);
    check_int("basic_hold_valid", int'(ct_valid), 1);
    check_vec("basic_hold_data", ct_data, NIST_CT0);
    check_vec("basic_hold_block", core_block, NIST_PT0);
    ct_ready = 1'b1;
    @(negedge clk);
    check_int("basic_ct_done", int'(ct_valid), 0);
    check_int("basic_blk_count", int'(blk_count), 1);
    check_int("basic_init_once", init_pulses, 1);

    // Burst of four NIST blocks
    snap_next = next_pulses; snap_rise = trig_rises; snap_cyc = trig_cycles;
    for (int i = 0; i < 4; i++) begin
      check_int($sformatf("burst_ready%0d", i), int'(pt_ready), 1);
      pt_data = pts[i]; pt_valid = 1'b1;
      @(negedge clk);
    end
    pt_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_v[i] = cts[i];
    collect("burst", 4);
    check_int("burst_blk_count", int'(blk_count), 5);
    check_int("burst_next_pulses", next_pulses - snap_next, 4);
    check_int("burst_trig_rises", trig_rises - snap_rise, 4);
    check_int("burst_trig_cycles", trig_cycles - snap_cyc, 4 * (LAT + 3));

    // Backpressure: five pushes fill the FIFO behind the block in flight
    ct_ready = 1'b0;
    bp[0] = NIST_PT0; bp[1] = NIST_PT1; bp[2] = NIST_PT2; bp[3] = NIST_PT3; bp[4] = X1;
    for (int i = 0; i < 5; i++) begin
      check_int($sformatf("bp_ready%0d", i), int'(pt_ready), 1);
      pt_data = bp[i]; pt_valid = 1'b1;
      @(negedge clk);
    end
    check_int("bp_full", int'(pt_ready), 0);
    pt_data = X2;
    wait_for("bp_ct_valid", 2, 30);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(ct_valid === 1'b1 && ct_data === NIST_CT0 && pt_ready === 1'b0)) stable = 1'b0;
    end
    check_int("bp_stable", int'(stable), 1);
    ct_ready = 1'b1;
    exp_v[0] = NIST_CT0; exp_v[1] = NIST_CT1; exp_v[2] = NIST_CT2;
    exp_v[3] = NIST_CT3; exp_v[4] = ~X1; exp_v[5] = ~X2;
    collect("bp", 6);
    pt_valid = 1'b0;
    check_int("bp_blk_count", int'(blk_count), 11);

    // Timeout: stub never finishes the next block
    stub_hang = 1'b1;
    push_one(X3);
    wait_for("to_next", 1, 10);
    repeat (TO + 1) @(negedge clk);
    check_int("to_before", int'({timeout_err, trigger}), 1);
    @(negedge clk);
    check_int("to_err", int'(timeout_err), 1);
    check_int("to_outputs_low", int'({ct_valid, trigger, pt_ready}), 0);
    check_int("to_busy", int'(busy), 1);
    pt_valid = 1'b1;
    repeat (5) @(negedge clk);
    pt_valid = 1'b0;
    check_int("to_stays", int'({timeout_err, ct_valid, trigger, pt_ready}), 8);

    // Reset out of ERR clears the sticky flag asynchronously
    #2 reset = 1'b1;
    #1;
    check_int("err_rst_flag", int'(timeout_err), 0);
    check_int("err_rst_blk_count", int'(blk_count), 0);
    @(negedge clk);
    reset = 1'b0; stub_hang = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for("rst2_init_done", 0, 30);

    // Reset during NEXT_WAIT
    push_one(NIST_PT1);
    wait_for("mid_next", 1, 10);
    repeat (3) @(negedge clk);
    check_int("mid_in_wait", int'({trigger, busy}), 3);
    #2 reset = 1'b1;
    #1;
    check_int("mid_rst_ctl", int'({core_init, core_next, ct_valid, trigger, busy, timeout_err, pt_ready}), 0);
    check_vec("mid_rst_core_block", core_block, '0);
    check_vec("mid_rst_ct_data", ct_data, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for("post_rst_init_done", 0, 30);
    push_one(NIST_PT0);
    wait_for("post_rst_ct_valid", 2, 30);
    check_vec("post_rst_ct", ct_data, NIST_CT0);
    @(negedge clk);
    check_int("post_rst_blk_count", int'(blk_count), 1);

    check_int("init_next_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
